// File: rtl/frame_buffer_write_arbiter.sv
// rtl/frame_buffer_write_arbiter.sv - round-robin camera/overlay write arbiter with full-frame clear engine
module frame_buffer_write_arbiter #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1CamValid,
  output logic        poul1CamReady,
  input  logic [8:0]  piul9CamPosX,
  input  logic [8:0]  piul9CamPosY,
  input  logic [11:0] piul12CamRgb,
  input  logic        piul1OvlValid,
  output logic        poul1OvlReady,
  input  logic [8:0]  piul9OvlPosX,
  input  logic [8:0]  piul9OvlPosY,
  input  logic [11:0] piul12OvlRgb,
  input  logic        piul1ClearStart,
  input  logic [11:0] piul12ClearRgb,
  output logic        poul1ClearBusy,
  output logic        poul1ClearDone,
  output logic        poul1Update,
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb,
  output logic [15:0] poul16DropCount
);

  localparam logic [8:0] X_LAST = 9'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        last_ovl_q, last_ovl_d;
  logic [8:0]  clr_x_q, clr_x_d;
  logic [8:0]  clr_y_q, clr_y_d;
  logic [11:0] clr_rgb_q, clr_rgb_d;
  logic        update_q, update_d;
  logic [8:0]  pos_x_q, pos_x_d;
  logic [8:0]  pos_y_q, pos_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        clear_done_q, clear_done_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic        serving;
  logic        cam_ready;
  logic        ovl_ready;
  logic        accept;
  logic [8:0]  req_x;
  logic [8:0]  req_y;
  logic [11:0] req_rgb;

  // Ready depends combinationally on Valid; a tie goes to whoever was not granted last.
  always_comb begin
    serving   = !piul1Reset && (state_q == SERVE) && !piul1ClearStart;
    cam_ready = serving && piul1CamValid && (!piul1OvlValid || last_ovl_q);
    ovl_ready = serving && piul1OvlValid && (!piul1CamValid || !last_ovl_q);
    accept    = cam_ready || ovl_ready;
    req_x     = ovl_ready ? piul9OvlPosX : piul9CamPosX;
    req_y     = ovl_ready ? piul9OvlPosY : piul9CamPosY;
    req_rgb   = ovl_ready ? piul12OvlRgb : piul12CamRgb;
  end

  logic        clear_write;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_rgb;

  always_comb begin
    state_d      = state_q;
    last_ovl_d   = last_ovl_q;
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
    clr_rgb_d    = clr_rgb_q;
    update_d     = 1'b0;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    rgb_d        = rgb_q;
    clear_done_d = 1'b0;
    drop_count_d = drop_count_q;
    clear_write  = 1'b0;
    wr_x         = clr_x_q;
    wr_y         = clr_y_q;
    wr_rgb       = clr_rgb_q;

    case (state_q)
      SERVE: begin
        if (piul1ClearStart) begin
          // Pixel (0,0) is issued from the start cycle so it lands right after ClearStart.
          state_d     = CLEAR;
          clr_rgb_d   = piul12ClearRgb;
          clear_write = 1'b1;
          wr_x        = '0;
          wr_y        = '0;
          wr_rgb      = piul12ClearRgb;
        end else if (accept) begin
          last_ovl_d = ovl_ready;
          if ((req_x <= X_LAST) && (req_y <= Y_LAST)) begin
            update_d = 1'b1;
            pos_x_d  = req_x;
            pos_y_d  = req_y;
            rgb_d    = req_rgb;
          end else if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end
        end
      end
      CLEAR: begin
        // The cycle showing ClearDone is the last busy cycle; requesters resume after it.
        if (clear_done_q) begin
          state_d = SERVE;
        end else begin
          clear_write = 1'b1;
        end
      end
      default: state_d = SERVE;
    endcase

    if (clear_write) begin
      update_d = 1'b1;
      pos_x_d  = wr_x;
      pos_y_d  = wr_y;
      rgb_d    = wr_rgb;
      if (wr_x == X_LAST) begin
        clr_x_d      = '0;
        clr_y_d      = wr_y + 9'd1;
        clear_done_d = (wr_y == Y_LAST);
      end else begin
        clr_x_d = wr_x + 9'd1;
        clr_y_d = wr_y;
      end
    end
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q      <= SERVE;
      last_ovl_q   <= 1'b1;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      clr_rgb_q    <= '0;
      update_q     <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      rgb_q        <= '0;
      clear_done_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_ovl_q   <= last_ovl_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      clr_rgb_q    <= clr_rgb_d;
      update_q     <= update_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      rgb_q        <= rgb_d;
      clear_done_q <= clear_done_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign poul1CamReady   = cam_ready;
  assign poul1OvlReady   = ovl_ready;
  assign poul1ClearBusy  = (state_q == CLEAR);
  assign poul1ClearDone  = clear_done_q;
  assign poul1Update     = update_q;
  assign poul9PosX       = pos_x_q;
  assign poul9PosY       = pos_y_q;
  assign poul12Rgb       = rgb_q;
  assign poul16DropCount = drop_count_q;

endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// tb/tb_frame_buffer_write_arbiter.sv - scoreboard bench for frame_buffer_write_arbiter
module tb_frame_buffer_write_arbiter;

  localparam int H = 320;
  localparam int V = 240;
  localparam int FRAME = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cam_valid, ovl_valid, clr_start;
  logic [8:0]  cam_x, cam_y, ovl_x, ovl_y;
  logic [11:0] cam_rgb, ovl_rgb, clr_rgb;
  logic        cam_ready, ovl_ready, busy, done, update;
  logic [8:0]  pos_x, pos_y;
  logic [11:0] rgb;
  logic [15:0] drop;

  frame_buffer_write_arbiter dut (
    .piul1Clock(clk), .piul1Reset(rst),
    .piul1CamValid(cam_valid), .poul1CamReady(cam_ready),
    .piul9CamPosX(cam_x), .piul9CamPosY(cam_y), .piul12CamRgb(cam_rgb),
    .piul1OvlValid(ovl_valid), .poul1OvlReady(ovl_ready),
    .piul9OvlPosX(ovl_x), .piul9OvlPosY(ovl_y), .piul12OvlRgb(ovl_rgb),
    .piul1ClearStart(clr_start), .piul12ClearRgb(clr_rgb),
    .poul1ClearBusy(busy), .poul1ClearDone(done), .poul1Update(update),
    .poul9PosX(pos_x), .poul9PosY(pos_y), .poul12Rgb(rgb), .poul16DropCount(drop)
  );

  // Second instance fed a continuous out-of-range stream to reach drop-count saturation.
  logic        rst2, s_cam_ready, s_ovl_ready, s_busy, s_done, s_update;
  logic [8:0]  s_pos_x, s_pos_y;
  logic [11:0] s_rgb;
  logic [15:0] s_drop;

  frame_buffer_write_arbiter dut_sat (
    .piul1Clock(clk), .piul1Reset(rst2),
    .piul1CamValid(1'b1), .poul1CamReady(s_cam_ready),
    .piul9CamPosX(9'd320), .piul9CamPosY(9'd0), .piul12CamRgb(12'h555),
    .piul1OvlValid(1'b0), .poul1OvlReady(s_ovl_ready),
    .piul9OvlPosX(9'd0), .piul9OvlPosY(9'd0), .piul12OvlRgb(12'h000),
    .piul1ClearStart(1'b0), .piul12ClearRgb(12'h000),
    .poul1ClearBusy(s_busy), .poul1ClearDone(s_done), .poul1Update(s_update),
    .poul9PosX(s_pos_x), .poul9PosY(s_pos_y), .poul12Rgb(s_rgb), .poul16DropCount(s_drop)
  );

  int tests = 0;
  int fails = 0;

  function automatic void cmp(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int x;
    int y;
    int rgb;
    bit last;
  } wr_t;

  wr_t exp_q[$];
  int  done_seen = 0;

  // Reference model state: arbitration history, drop counter, clear progress.
  bit  m_last_ovl = 1'b1;
  int  m_drop = 0;
  int  m_clr_rem = 0;
  int  m_clr_idx = 0;
  int  m_clr_rgb = 0;
  bit  g_cam, g_ovl;
  bit  s_cam, s_ovl;

  function automatic void push(int x, int y, int c, bit last);
    wr_t e;
    e.x = x; e.y = y; e.rgb = c; e.last = last;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    bit serve;
    @(negedge clk);
    cmp("clear_busy", busy, (m_clr_rem > 0));
    cmp("drop_count", drop, m_drop);
    serve = !rst && (m_clr_rem == 0) && !clr_start;
    if (serve && cam_valid && ovl_valid) begin
      g_cam = m_last_ovl;
      g_ovl = !m_last_ovl;
    end else begin
      g_cam = serve && cam_valid;
      g_ovl = serve && ovl_valid;
    end
    cmp("cam_ready", cam_ready, g_cam);
    cmp("ovl_ready", ovl_ready, g_ovl);
    s_cam = cam_ready;
    s_ovl = ovl_ready;
    if (rst) begin
      m_last_ovl = 1'b1;
      m_drop = 0;
      m_clr_rem = 0;
    end else if (m_clr_rem > 0) begin
      if (m_clr_idx < FRAME) begin
        push(m_clr_idx % H, m_clr_idx / H, m_clr_rgb, m_clr_idx == FRAME - 1);
        m_clr_idx++;
      end
      m_clr_rem--;
    end else if (clr_start) begin
      m_clr_rgb = int'(clr_rgb);
      push(0, 0, m_clr_rgb, FRAME == 1);
      m_clr_idx = 1;
      m_clr_rem = FRAME;
    end else if (g_cam || g_ovl) begin
      int x, y, c;
      x = g_ovl ? int'(ovl_x) : int'(cam_x);
      y = g_ovl ? int'(ovl_y) : int'(cam_y);
      c = g_ovl ? int'(ovl_rgb) : int'(cam_rgb);
      m_last_ovl = g_ovl;
      if (x < H && y < V) push(x, y, c, 1'b0);
      else if (m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    wr_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (update) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_update", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cmp("write_xy_rgb_done", {pos_x, pos_y, rgb, done},
              {9'(e.x), 9'(e.y), 12'(e.rgb), e.last});
          if (done) done_seen++;
        end
      end else if (done) begin
        cmp("done_without_update", 1, 0);
      end
    end
  end

  bit sat_done = 1'b0;

  initial begin
    bit upd_seen = 1'b0;
    bit nrdy_seen = 1'b0;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (i == 0 || i == 1 || i == 1000 || i == 65534 || i == 65535 || i == 65539)
        cmp("sat_drop_count", s_drop, (i < 65535) ? i : 65535);
      if (s_update) upd_seen = 1'b1;
      if (!s_cam_ready) nrdy_seen = 1'b1;
    end
    cmp("sat_no_update", upd_seen, 0);
    cmp("sat_always_ready", nrdy_seen, 0);
    sat_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tie_cam[4];
    rst = 1'b1; clr_start = 1'b0; clr_rgb = 12'h000;
    cam_valid = 1'b1; cam_x = 9'd10; cam_y = 9'd20; cam_rgb = 12'h111;
    ovl_valid = 1'b1; ovl_x = 9'd30; ovl_y = 9'd40; ovl_rgb = 12'h222;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 1'b0;

    // Tie right after reset: camera must win first.
    for (int i = 0; i < 4; i++) begin
      step();
      tie_cam[i] = s_cam;
      cmp("tie_one_ready", int'(s_cam) + int'(s_ovl), 1);
    end
    cmp("tie_order", {tie_cam[0], tie_cam[1], tie_cam[2], tie_cam[3]}, 4'b1010);

    ovl_valid = 1'b0;
    cam_x = 9'd5; cam_y = 9'd7; cam_rgb = 12'hABC;
    step();
    cmp("single_ready0", s_cam, 1);
    cam_x = 9'd6; cam_y = 9'd7; cam_rgb = 12'h123;
    step();
    cmp("single_ready1", s_cam, 1);
    cam_valid = 1'b0;
    step();

    cam_valid = 1'b1; cam_x = 9'd320; cam_y = 9'd0;
    step();
    cam_x = 9'd0; cam_y = 9'd240;
    step();
    cam_valid = 1'b0;
    cmp("oor_drop_two", drop, 2);
    step();

    for (int i = 0; i < 300; i++) begin
      if (!cam_valid || g_cam) begin
        cam_valid = ($urandom_range(0, 3) != 0);
        cam_x = 9'($urandom_range(0, H + 8));
        cam_y = 9'($urandom_range(0, V + 8));
        cam_rgb = 12'($urandom);
      end
      if (!ovl_valid || g_ovl) begin
        ovl_valid = ($urandom_range(0, 2) != 0);
        ovl_x = 9'($urandom_range(0, H + 8));
        ovl_y = 9'($urandom_range(0, V + 8));
        ovl_rgb = 12'($urandom);
      end
      step();
    end
    cam_valid = 1'b0; ovl_valid = 1'b0;
    step();

    // Overlay is granted last before the clear, so camera should win afterwards.
    ovl_valid = 1'b1; ovl_x = 9'd100; ovl_y = 9'd100; ovl_rgb = 12'h7E7;
    step();
    cam_valid = 1'b1; cam_x = 9'd1; cam_y = 9'd2; cam_rgb = 12'h333;
    ovl_x = 9'd3; ovl_y = 9'd4; ovl_rgb = 12'h444;
    clr_start = 1'b1; clr_rgb = 12'h0F0;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < FRAME; i++) step();
    cmp("clear_done_count", done_seen, 1);
    step();
    cmp("post_clear_cam_first", {s_cam, s_ovl}, 2'b10);
    cam_valid = 1'b0; ovl_valid = 1'b0;
    repeat (3) step();

    clr_start = 1'b1; clr_rgb = 12'hF00;
    step();
    clr_start = 1'b0;
    for (int i = 1; i < 1000; i++) begin
      clr_start = (i == 500);
      step();
    end
    clr_start = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    cmp("abort_busy_low", busy, 0);
    cmp("abort_no_done", done_seen, 1);
    cmp("queue_drained", exp_q.size(), 0);
    cmp("saturation_finished", sat_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
